// File: rtl/fast_control_rx.sv
// fast_control_rx: Hamming(8,4) SECDED fast-control receiver with BCR-locked BX counter and link-quality counters.
// Optional feature: define FC_RX_L1A_GATE_EN to block l1a/calib_pulse/buffer_clear while unlocked.
module fast_control_rx #(
    parameter int unsigned LOCK_BCRS     = 4,
    parameter int unsigned UNLOCK_MISSES = 2
) (
    input  logic        clk_bx,
    input  logic        reset,
    input  logic [15:0] fc_stream_enc,
    input  logic [11:0] orb_length,
    input  logic        err_clear,
    output logic        bcr,
    output logic        l1a,
    output logic        link_reset,
    output logic        buffer_clear,
    output logic        calib_pulse,
    output logic [11:0] bx_id,
    output logic [11:0] l1a_bxid,
    output logic [23:0] event_count,
    output logic        locked,
    output logic [15:0] sec_count,
    output logic [15:0] ded_count,
    output logic [15:0] misalign_count
);

    localparam int unsigned GW = $clog2(LOCK_BCRS + 1);
    localparam int unsigned MW = $clog2(UNLOCK_MISSES + 1);
    localparam logic [GW-1:0] GOOD_TARGET = GW'(LOCK_BCRS);
    localparam logic [MW-1:0] MISS_TARGET = MW'(UNLOCK_MISSES);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

    typedef struct packed {
        logic [3:0] data;
        logic       sec;
        logic       ded;
    } dec_t;

    // Code byte: bit i (1..7) is Hamming position i (p1,p2,d0,p3,d1,d2,d3); bit 0 is overall even parity.
    function automatic dec_t hdec(input logic [7:0] b);
        dec_t       r;
        logic [2:0] syn;
        logic       par;
        logic [7:0] c;
        syn = {b[4] ^ b[5] ^ b[6] ^ b[7], b[2] ^ b[3] ^ b[6] ^ b[7], b[1] ^ b[3] ^ b[5] ^ b[7]};
        par = ^b;
        c   = b;
        if (par) c[syn] = ~b[syn];
        r.data = {c[7], c[6], c[5], c[3]};
        r.sec  = par;
        r.ded  = !par && (syn != 3'd0);
        if (r.ded) r.data = '0;
        return r;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] inc);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, inc};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    logic [15:0]   word_q;
    dec_t          dec_lo, dec_hi;
    logic          cmd_bcr, cmd_l1a, cmd_lr, cmd_bc, cmd_cal;
    logic [1:0]    sec_inc, ded_inc;
    logic          gate, emit_l1a, emit_bc, emit_cal;
    logic          at_end, aligned, misaligned, missing;
    logic          unused_cmd;
    state_t        state, state_n;
    logic [GW-1:0] good, good_n;
    logic [MW-1:0] miss, miss_n;
    logic          miss_evt;

    always_ff @(posedge clk_bx) begin
        if (reset) word_q <= '0;
        else       word_q <= fc_stream_enc;
    end

    always_comb begin
        dec_lo  = hdec(word_q[7:0]);
        dec_hi  = hdec(word_q[15:8]);
        cmd_bcr = dec_lo.data[0];
        cmd_l1a = dec_lo.data[1];
        cmd_lr  = dec_lo.data[2];
        cmd_bc  = dec_lo.data[3];
        cmd_cal = dec_hi.data[1];
        sec_inc = {1'b0, dec_lo.sec} + {1'b0, dec_hi.sec};
        ded_inc = {1'b0, dec_lo.ded} + {1'b0, dec_hi.ded};
    end

    // Command bits 4, 6 and 7 carry nothing for this receiver.
    assign unused_cmd = ^{dec_hi.data[3:2], dec_hi.data[0]};

`ifdef FC_RX_L1A_GATE_EN
    assign gate = locked;
`else
    assign gate = 1'b1;
`endif

    assign emit_l1a   = cmd_l1a & gate;
    assign emit_bc    = cmd_bc & gate;
    assign emit_cal   = cmd_cal & gate;
    assign at_end     = (bx_id == orb_length - 12'd1);
    assign aligned    = cmd_bcr & at_end;
    assign misaligned = cmd_bcr & ~at_end;
    assign missing    = ~cmd_bcr & at_end;
    assign locked     = (state == LOCKED);

    always_ff @(posedge clk_bx) begin
        if (reset) begin
            state <= UNLOCKED;
            good  <= '0;
            miss  <= '0;
        end else begin
            state <= state_n;
            good  <= good_n;
            miss  <= miss_n;
        end
    end

    always_comb begin
        state_n  = state;
        good_n   = good;
        miss_n   = miss;
        miss_evt = 1'b0;
        case (state)
            UNLOCKED: begin
                if (cmd_bcr) begin
                    state_n = ACQUIRE;
                    good_n  = GW'(1);
                end
            end
            ACQUIRE: begin
                if (aligned) begin
                    good_n = good + GW'(1);
                    if (good + GW'(1) == GOOD_TARGET) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                    end
                end else if (misaligned) begin
                    good_n = GW'(1);
                end else if (missing) begin
                    state_n = UNLOCKED;
                    good_n  = '0;
                end
            end
            LOCKED: begin
                if (aligned) begin
                    miss_n = '0;
                end else if (misaligned || missing) begin
                    miss_evt = 1'b1;
                    miss_n   = miss + MW'(1);
                    if (miss + MW'(1) == MISS_TARGET) begin
                        state_n = UNLOCKED;
                        miss_n  = '0;
                        good_n  = '0;
                    end
                end
            end
            default: state_n = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_bx) begin
        if (reset) begin
            bcr            <= 1'b0;
            l1a            <= 1'b0;
            link_reset     <= 1'b0;
            buffer_clear   <= 1'b0;
            calib_pulse    <= 1'b0;
            bx_id          <= '0;
            l1a_bxid       <= '0;
            event_count    <= '0;
            sec_count      <= '0;
            ded_count      <= '0;
            misalign_count <= '0;
        end else begin
            bcr          <= cmd_bcr;
            l1a          <= emit_l1a;
            link_reset   <= cmd_lr;
            buffer_clear <= emit_bc;
            calib_pulse  <= emit_cal;
            bx_id        <= (cmd_bcr || at_end) ? '0 : bx_id + 12'd1;
            if (emit_l1a) l1a_bxid <= bx_id;
            if (emit_bc)       event_count <= '0;
            else if (emit_l1a) event_count <= event_count + 24'd1;
            if (err_clear) begin
                sec_count      <= '0;
                ded_count      <= '0;
                misalign_count <= '0;
            end else begin
                sec_count      <= sat_add(sec_count, sec_inc);
                ded_count      <= sat_add(ded_count, ded_inc);
                misalign_count <= sat_add(misalign_count, {1'b0, miss_evt});
            end
        end
    end

endmodule

// File: tb/tb_fast_control_rx.sv
// Scoreboard bench for fast_control_rx: stimulus pushes expected pulse records, a monitor pops them on every pulse.
// Honours FC_RX_L1A_GATE_EN for the gated expectations.
module tb_fast_control_rx;

    localparam logic [11:0] ORB = 12'd45;
    localparam logic [7:0] C_BCR = 8'h01, C_L1A = 8'h02, C_LR = 8'h04, C_BC = 8'h08, C_CAL = 8'h20;

    logic        clk_bx = 1'b0;
    logic        reset;
    logic [15:0] fc_stream_enc;
    logic [11:0] orb_length;
    logic        err_clear;
    logic        bcr, l1a, link_reset, buffer_clear, calib_pulse, locked;
    logic [11:0] bx_id, l1a_bxid;
    logic [23:0] event_count;
    logic [15:0] sec_count, ded_count, misalign_count;

    fast_control_rx #(.LOCK_BCRS(4), .UNLOCK_MISSES(2)) dut (
        .clk_bx(clk_bx), .reset(reset), .fc_stream_enc(fc_stream_enc), .orb_length(orb_length),
        .err_clear(err_clear), .bcr(bcr), .l1a(l1a), .link_reset(link_reset),
        .buffer_clear(buffer_clear), .calib_pulse(calib_pulse), .bx_id(bx_id), .l1a_bxid(l1a_bxid),
        .event_count(event_count), .locked(locked), .sec_count(sec_count), .ded_count(ded_count),
        .misalign_count(misalign_count)
    );

    always #5 clk_bx = ~clk_bx;

    typedef struct {
        logic [4:0]  pulses;   // {calib, buffer_clear, link_reset, l1a, bcr}
        logic [11:0] bx;
        logic [11:0] l1a_bxid;
        logic [23:0] ev;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          fails  = 0;
    logic [11:0] bx_pre;
    logic [11:0] exp_l1a_bxid = '0;
    logic [23:0] exp_ev = '0;
    logic        exp_locked = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] h84(input logic [3:0] d);
        logic [7:0] b;
        b[1] = d[0] ^ d[1] ^ d[3];
        b[2] = d[0] ^ d[2] ^ d[3];
        b[3] = d[0];
        b[4] = d[1] ^ d[2] ^ d[3];
        b[5] = d[1];
        b[6] = d[2];
        b[7] = d[3];
        b[0] = ^b[7:1];
        return b;
    endfunction

    function automatic logic [15:0] enc16(input logic [7:0] c);
        return {h84(c[7:4]), h84(c[3:0])};
    endfunction

    task automatic send_raw(input logic [15:0] enc, input logic [7:0] cmd, input logic ec);
        exp_t       e;
        logic [4:0] p;
        logic       g;
        @(negedge clk_bx);
        fc_stream_enc = enc;
        err_clear     = ec;
`ifdef FC_RX_L1A_GATE_EN
        g = exp_locked;
`else
        g = 1'b1;
`endif
        p = {cmd[5] & g, cmd[3] & g, cmd[2], cmd[1] & g, cmd[0]};
        if (p[1]) exp_l1a_bxid = bx_pre;
        if (p[3])      exp_ev = '0;
        else if (p[1]) exp_ev = exp_ev + 24'd1;
        bx_pre = (cmd[0] || bx_pre == ORB - 12'd1) ? 12'd0 : bx_pre + 12'd1;
        if (p != 5'd0) begin
            e.pulses = p; e.bx = bx_pre; e.l1a_bxid = exp_l1a_bxid; e.ev = exp_ev;
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [7:0] cmd);
        send_raw(enc16(cmd), cmd, 1'b0);
    endtask

    task automatic idle2();
        send(8'h00);
        send(8'h00);
    endtask

    task automatic goto_slot(input logic [11:0] target);
        for (int i = 0; i < 4096 && bx_pre != target; i++) send(8'h00);
    endtask

    task automatic sync_bcr();
        goto_slot(ORB - 12'd1);
        send(C_BCR);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_bx);
            #1;
            if (|{calib_pulse, buffer_clear, link_reset, l1a, bcr}) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 32'({calib_pulse, buffer_clear, link_reset, l1a, bcr}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulses", 32'({calib_pulse, buffer_clear, link_reset, l1a, bcr}), 32'(e.pulses));
                    chk("bx_id_at_pulse", 32'(bx_id), 32'(e.bx));
                    chk("l1a_bxid_at_pulse", 32'(l1a_bxid), 32'(e.l1a_bxid));
                    chk("event_count_at_pulse", 32'(event_count), 32'(e.ev));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        reset = 1'b1; fc_stream_enc = '0; err_clear = 1'b0; orb_length = ORB;
        repeat (3) @(negedge clk_bx);
        chk("rst_bx_id", 32'(bx_id), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_event_count", 32'(event_count), 32'd0);
        chk("rst_l1a_bxid", 32'(l1a_bxid), 32'd0);
        chk("rst_counters", 32'({sec_count, ded_count} | 32'(misalign_count)), 32'd0);
        chk("rst_pulses", 32'({calib_pulse, buffer_clear, link_reset, l1a, bcr}), 32'd0);
        reset = 1'b0;
        // Two flushed idle words pass through the pipeline before the first sent word is decoded.
        bx_pre = 12'd2;

        send(C_L1A);
        idle2();
`ifdef FC_RX_L1A_GATE_EN
        chk("unlocked_l1a_event_count", 32'(event_count), 32'd0);
`else
        chk("unlocked_l1a_event_count", 32'(event_count), 32'd1);
`endif

        send(C_BCR);
        sync_bcr();
        sync_bcr();
        idle2();
        chk("locked_after_3_bcr", 32'(locked), 32'd0);
        sync_bcr();
        exp_locked = 1'b1;
        idle2();
        chk("locked_after_4_bcr", 32'(locked), 32'd1);

        send(C_BC);
        idle2();
        chk("event_count_buffer_clear", 32'(event_count), 32'd0);

        sync_bcr();
        goto_slot(12'd10);
        send(C_L1A);
        goto_slot(12'd30);
        send(C_L1A);
        idle2();
        chk("event_count_two_l1a", 32'(event_count), 32'd2);
        chk("l1a_bxid_30", 32'(l1a_bxid), 32'd30);

        sync_bcr();
        send(C_LR);
        send(C_CAL);
        send(8'hD0);
        send(C_L1A | C_LR | C_CAL);
        idle2();
        send_raw(enc16(C_L1A) ^ 16'h4020, C_L1A, 1'b0);
        idle2();
        chk("sec_count_2", 32'(sec_count), 32'd2);
        chk("ded_count_0", 32'(ded_count), 32'd0);
        send_raw(enc16(C_L1A) ^ 16'h0028, 8'h00, 1'b0);
        idle2();
        chk("ded_count_1", 32'(ded_count), 32'd1);
        send_raw(enc16(C_L1A) ^ 16'h0303, 8'h00, 1'b0);
        idle2();
        chk("ded_count_both_nibbles", 32'(ded_count), 32'd3);

        send(C_L1A); send(C_L1A); send(C_L1A);
        idle2();
        chk("event_count_7", 32'(event_count), 32'd7);
        send(C_BC | C_L1A);
        idle2();
        chk("event_count_bc_priority", 32'(event_count), 32'd0);

        send_raw(enc16(C_L1A) ^ 16'h0001, C_L1A, 1'b0);
        send_raw(16'h0000, 8'h00, 1'b1);
        send_raw(16'h0000, 8'h00, 1'b0);
        chk("sec_count_err_clear", 32'(sec_count), 32'd0);
        chk("ded_count_err_clear", 32'(ded_count), 32'd0);

        sync_bcr();
        goto_slot(ORB - 12'd1);
        send(8'h00);
        idle2();
        chk("misalign_count_1", 32'(misalign_count), 32'd1);
        chk("still_locked_1_miss", 32'(locked), 32'd1);
        goto_slot(ORB - 12'd1);
        send(8'h00);
        exp_locked = 1'b0;
        idle2();
        chk("misalign_count_2", 32'(misalign_count), 32'd2);
        chk("unlocked_2_miss", 32'(locked), 32'd0);

        send(C_L1A);
        idle2();
`ifdef FC_RX_L1A_GATE_EN
        chk("unlocked_l1a_gated", 32'(event_count), 32'd1);
`else
        chk("unlocked_l1a_passes", 32'(event_count), 32'd2);
`endif

        sync_bcr(); sync_bcr(); sync_bcr();
        idle2();
        chk("relock_after_3", 32'(locked), 32'd0);
        sync_bcr();
        exp_locked = 1'b1;
        idle2();
        chk("relock_after_4", 32'(locked), 32'd1);

        goto_slot(12'd20);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(negedge clk_bx);
        reset = 1'b1;
        @(posedge clk_bx);
        #1;
        chk("midorbit_reset_locked", 32'(locked), 32'd0);
        chk("midorbit_reset_bx_id", 32'(bx_id), 32'd0);
        chk("midorbit_reset_event_count", 32'(event_count), 32'd0);
        chk("midorbit_reset_misalign", 32'(misalign_count), 32'd0);
        repeat (2) @(negedge clk_bx);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
